// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one full-adder cell reused LSB first over WIDTH clocks.
// Produces result plus N/Z/V/carry flags with a start/busy/done handshake.

module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic sub,
    output logic s,
    output logic cout
);
    logic bx;

    assign bx   = b ^ sub;
    assign s    = a ^ bx ^ cin;
    assign cout = (a & bx) | (a & cin) | (bx & cin);
endmodule

module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovfl,
    output logic             zero,
    output logic             neg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] sa, sb, sr, sr_next;
    logic [CNT_W-1:0] cnt;
    logic             c;
    logic             subl;
    logic             fa_s, fa_cout;
    logic             last;

    full_adder_1bit u_fa (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (c),
        .sub  (subl),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign sr_next = {fa_s, sr[WIDTH-1:1]};
    assign last    = (cnt == CNT_W'(WIDTH - 1));
    assign busy    = (state == RUN);
    assign done    = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            cnt    <= '0;
            c      <= 1'b0;
            subl   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovfl   <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa   <= a;
                        sb   <= b;
                        subl <= sub;
                        // Initial carry of 1 completes A + ~B + 1
                        c    <= sub;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    c   <= fa_cout;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sr  <= sr_next;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        result <= sr_next;
                        cout   <= fa_cout;
                        // c still holds the carry into the MSB here
                        ovfl   <= c ^ fa_cout;
                        zero   <= (sr_next == '0);
                        neg    <= fa_s;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: vector table plus handshake,
// back-to-back start and mid-operation reset sequences.

module tb_serial_addsub;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             sub;
    logic             busy, done;
    logic [WIDTH-1:0] result;
    logic             cout, ovfl, zero, neg;

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH-1:0] exp_prev;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] res;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } vec_t;

    vec_t vecs[10];

    serial_addsub #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .sub    (sub),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovfl   (ovfl),
        .zero   (zero),
        .neg    (neg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation and check timing, stability and final flags.
    task automatic run_op(input vec_t v, input string tag);
        int t;
        int busy_cnt;
        bit seen;
        bit overlap;
        bit unstable;
        @(negedge clk);
        a = v.a; b = v.b; sub = v.sub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~v.a; b = ~v.b; sub = ~v.sub;
        t = 0; busy_cnt = 0; seen = 0; overlap = 0; unstable = 0;
        while (t < WIDTH + 6 && !seen) begin
            if (busy && done) overlap = 1;
            if (done) seen = 1;
            else begin
                if (busy) busy_cnt++;
                if (result !== exp_prev) unstable = 1;
                t++;
                @(negedge clk);
            end
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(t), 32'(WIDTH));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
        check({tag, " overlap"}, 32'(overlap), 32'd0);
        check({tag, " hold"}, 32'(unstable), 32'd0);
        check({tag, " result"}, 32'(result), 32'(v.res));
        check({tag, " cout"}, 32'(cout), 32'(v.c));
        check({tag, " ovfl"}, 32'(ovfl), 32'(v.v));
        check({tag, " zero"}, 32'(zero), 32'(v.z));
        check({tag, " neg"}, 32'(neg), 32'(v.n));
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        exp_prev = v.res;
    endtask

    initial begin
        int t;
        int done_cnt;
        int first_t;
        int last_t;
        bit late_done;
        int times[3];
        int k;

        vecs[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h4B4B, 1'b1, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
        exp_prev = '0;
        repeat (3) @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst outs", 32'({result, cout, ovfl, zero, neg}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // Start re-asserted mid-RUN with new operands must be ignored.
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0; done_cnt = 0; first_t = -1;
        while (t < 3 * WIDTH) begin
            if (t == 3) begin
                start = 1'b1; a = 16'h1234; b = 16'h1111;
            end
            if (done) begin
                done_cnt++;
                if (first_t < 0) begin
                    first_t = t;
                    start = 1'b0;
                    check("hs result", 32'(result), 32'h0002);
                end
            end
            t++;
            @(negedge clk);
        end
        check("hs first_done", 32'(first_t), 32'(WIDTH));
        check("hs done_count", 32'(done_cnt), 32'd1);
        check("hs idle_after", 32'(busy), 32'd0);
        exp_prev = 16'h0002;

        // Start held high: one operation every WIDTH+2 cycles.
        @(negedge clk);
        a = 16'h0002; b = 16'h0003; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        t = 0; k = 0;
        while (t < 4 * (WIDTH + 2) && k < 3) begin
            if (done) begin
                times[k] = t;
                k++;
                check("bb result", 32'(result), 32'h0005);
            end
            t++;
            @(negedge clk);
        end
        start = 1'b0;
        check("bb ops", 32'(k), 32'd3);
        if (k == 3) begin
            check("bb first", 32'(times[0]), 32'(WIDTH));
            check("bb gap1", 32'(times[1] - times[0]), 32'(WIDTH + 2));
            check("bb gap2", 32'(times[2] - times[1]), 32'(WIDTH + 2));
        end
        repeat (WIDTH + 4) @(negedge clk);
        check("bb drained", 32'(busy | done), 32'd0);
        exp_prev = 16'h0005;

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("mid busy_before", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst done", 32'(done), 32'd0);
        check("mid rst outs", 32'({result, cout, ovfl, zero, neg}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        late_done = 0;
        last_t = 0;
        repeat (WIDTH + 6) begin
            if (done || busy) late_done = 1;
            @(negedge clk);
        end
        check("mid no_done", 32'(late_done), 32'd0);
        exp_prev = '0;
        run_op('{16'h0002, 16'h0002, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0},
               "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
